// File: rtl/f52_to_f32_sched_pkg.sv
// Shared F52/F32 field layout, bias constants and range-flag helper
// for the F52 -> F32 conversion scheduler.
package fcvt_pkg;

    localparam int F52_SW = 1;
    localparam int F52_EW = 11;
    localparam int F52_MW = 40;
    localparam int F52_W  = F52_SW + F52_EW + F52_MW;

    localparam int F32_SW = 1;
    localparam int F32_EW = 8;
    localparam int F32_MW = 23;
    localparam int F32_W  = F32_SW + F32_EW + F32_MW;

    localparam int TRUNC_W = F52_MW - F32_MW;

    localparam logic [F52_EW-1:0] BIAS52 = 11'h3FF;
    localparam logic [F32_EW-1:0] BIAS32 = 8'h7F;

    // F52 exponent range that maps onto F32 normals: [E52_MIN, E52_MAX]
    localparam logic [F52_EW-1:0] E52_OFS  = BIAS52 - F52_EW'(BIAS32);
    localparam logic [F52_EW-1:0] E52_MAX  = BIAS52 + F52_EW'(BIAS32);
    localparam logic [F52_EW-1:0] E52_MIN  = E52_OFS + 1'b1;
    localparam logic [F52_EW-1:0] E52_SPEC = '1;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } fcvt_flags_t;

    function automatic fcvt_flags_t fcvt_flags(input logic [F52_W-2:0] mag);
        fcvt_flags_t      fl;
        logic [F52_EW-1:0] e;
        logic              nz;
        e      = mag[F52_W-2 -: F52_EW];
        nz     = |mag;
        fl.ovf = (e > E52_MAX) && (e != E52_SPEC);
        fl.unf = (e < E52_MIN) && nz;
        fl.inx = (|mag[TRUNC_W-1:0]) && !fl.ovf && !fl.unf && nz;
        return fl;
    endfunction

endpackage

// File: rtl/f52_to_f32_sched_if.sv
// Request and result handshake bundle between requesters, the shared
// converter pipeline and the result consumer.
interface f52_to_f32_sched_if
    import fcvt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*F52_W-1:0] req_a;
    logic [NREQ-1:0]       req_ready;

    logic                  out_valid;
    logic                  out_ready;
    logic [F32_W-1:0]      out_o;
    logic [IDW-1:0]        out_id;
    logic                  out_ovf;
    logic                  out_unf;
    logic                  out_inx;

    modport master (
        output req_valid, req_a, out_ready,
        input  req_ready, out_valid, out_o, out_id,
        input  out_ovf, out_unf, out_inx
    );

    modport slave (
        input  req_valid, req_a, out_ready,
        output req_ready, out_valid, out_o, out_id,
        output out_ovf, out_unf, out_inx
    );

endinterface

// File: rtl/f52_to_f32_sched_arb.sv
// Round-robin arbiter: first requester at or after ptr_i, wrapping,
// returned one-hot and encoded.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    int             j;
    logic [IDW-1:0] jj;

    // Scan farthest-first so the nearest requester to ptr_i wins last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        j       = 0;
        jj      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IDW'(j);
            if (req_i[jj]) begin
                grant_o     = '0;
                grant_o[jj] = 1'b1;
                idx_o       = jj;
            end
        end
    end

endmodule

// File: rtl/f52_to_f32_sched_cvt.sv
// Combinational F52 -> F32 converter: truncating mantissa, saturating
// to infinity above range, flushing to signed zero below.
module F52ToF32
    import fcvt_pkg::*;
(
    input  logic [F52_W-1:0] a_i,
    output logic [F32_W-1:0] f_o
);

    logic              sgn;
    logic [F52_EW-1:0] e;
    logic [F52_MW-1:0] m;
    logic [F32_MW-1:0] mt;
    logic [F32_MW-1:0] qnan;

    assign sgn  = a_i[F52_W-1];
    assign e    = a_i[F52_W-2 -: F52_EW];
    assign m    = a_i[F52_MW-1:0];
    assign mt   = m[F52_MW-1 -: F32_MW];
    assign qnan = {(|m), {(F32_MW-1){1'b0}}};

    always_comb begin
        f_o = {sgn, {(F32_W-1){1'b0}}};
        unique case (1'b1)
            (e == E52_SPEC):
                f_o = {sgn, {F32_EW{1'b1}}, mt | qnan};
            (e > E52_MAX) && (e != E52_SPEC):
                f_o = {sgn, {F32_EW{1'b1}}, {F32_MW{1'b0}}};
            (e < E52_MIN):
                f_o = {sgn, {(F32_W-1){1'b0}}};
            default:
                f_o = {sgn, F32_EW'(e - E52_OFS), mt};
        endcase
    end

endmodule

// File: rtl/f52_to_f32_sched.sv
// Shares one F52ToF32 converter between NREQ requesters through a
// round-robin arbiter and a two-stage valid/ready pipeline.
module f52_to_f32_sched
    import fcvt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    f52_to_f32_sched_if.slave bus,
    output logic              busy
);

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic [F52_W-1:0] opnd;
    logic [F32_W-1:0] cvt;
    logic             adv1, adv2, ld1;

    logic [IDW-1:0]   rr_q, rr_d;
    logic             s1_v_q, s1_v_d;
    logic [F52_W-1:0] s1_a_q, s1_a_d;
    logic [IDW-1:0]   s1_id_q, s1_id_d;
    fcvt_flags_t      s1_fl_q, s1_fl_d;
    logic             s2_v_q, s2_v_d;
    logic [F32_W-1:0] s2_o_q, s2_o_d;
    logic [IDW-1:0]   s2_id_q, s2_id_d;
    fcvt_flags_t      s2_fl_q, s2_fl_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_q),
        .grant_o (grant),
        .idx_o   (gidx)
    );

    F52ToF32 u_cvt (
        .a_i (s1_a_q),
        .f_o (cvt)
    );

    assign adv2 = ~s2_v_q | bus.out_ready;
    assign adv1 = ~s1_v_q | adv2;
    assign ld1  = adv1 & (|bus.req_valid) & ~flush & ~rst;
    assign opnd = bus.req_a[gidx*F52_W +: F52_W];

    always_comb begin
        rr_d    = rr_q;
        s1_v_d  = s1_v_q;
        s1_a_d  = s1_a_q;
        s1_id_d = s1_id_q;
        s1_fl_d = s1_fl_q;
        s2_v_d  = s2_v_q;
        s2_o_d  = s2_o_q;
        s2_id_d = s2_id_q;
        s2_fl_d = s2_fl_q;
        if (adv1) s1_v_d = ld1;
        if (adv2) s2_v_d = s1_v_q;
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end
        if (ld1) begin
            s1_a_d  = opnd;
            s1_id_d = gidx;
            s1_fl_d = fcvt_flags(opnd[F52_W-2:0]);
            rr_d    = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
        // Payload only moves with a real entry so idle outputs stay quiet.
        if (adv2 && s1_v_q && !flush) begin
            s2_o_d  = cvt;
            s2_id_d = s1_id_q;
            s2_fl_d = s1_fl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_id_q <= '0;
            s1_fl_q <= '0;
            s2_v_q  <= 1'b0;
            s2_o_q  <= '0;
            s2_id_q <= '0;
            s2_fl_q <= '0;
        end else begin
            rr_q    <= rr_d;
            s1_v_q  <= s1_v_d;
            s1_a_q  <= s1_a_d;
            s1_id_q <= s1_id_d;
            s1_fl_q <= s1_fl_d;
            s2_v_q  <= s2_v_d;
            s2_o_q  <= s2_o_d;
            s2_id_q <= s2_id_d;
            s2_fl_q <= s2_fl_d;
        end
    end

    assign bus.req_ready = grant & {NREQ{ld1}};
    assign bus.out_valid = s2_v_q;
    assign bus.out_o     = s2_o_q;
    assign bus.out_id    = s2_id_q;
    assign bus.out_ovf   = s2_fl_q.ovf;
    assign bus.out_unf   = s2_fl_q.unf;
    assign bus.out_inx   = s2_fl_q.inx;
    assign busy          = s1_v_q | s2_v_q;

endmodule
